// File: rtl/resp_sig_compactor.sv
// Response-side MISR compactor: folds each valid response sample into a signature,
// then offers signature, sample count and expected-signature match on a valid/ready port.
module resp_sig_compactor #(
  parameter int               DATA_W = 330,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_samples,
  input  logic [CNT_W-1:0]  skip,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              busy,
  output logic [SIG_W-1:0]  sig_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              match
);

  localparam int NSL = (DATA_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

  state_t               state, state_d;
  logic [SIG_W-1:0]     sig, sig_d, exp_lat, exp_d, fold, misr;
  logic [CNT_W-1:0]     cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0]     skip_cnt, skip_cnt_d, skip_inc;
  logic [CNT_W-1:0]     n_lat, n_d, skip_lat, skip_d;
  logic [NSL*SIG_W-1:0] padded;
  logic                 match_r, match_d;

  always_comb begin
    padded = '0;
    padded[DATA_W-1:0] = data_in;
    fold = '0;
    for (int unsigned k = 0; k < NSL; k++) begin
      fold ^= padded[k*SIG_W +: SIG_W];
    end
  end

  assign misr     = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign skip_inc = skip_cnt + CNT_W'(1);

  always_comb begin
    state_d    = state;
    sig_d      = sig;
    cnt_d      = cnt;
    skip_cnt_d = skip_cnt;
    n_d        = n_lat;
    skip_d     = skip_lat;
    exp_d      = exp_lat;
    case (state)
      IDLE: begin
        if (start) begin
          n_d        = n_samples;
          skip_d     = skip;
          exp_d      = exp_sig;
          sig_d      = SEED;
          cnt_d      = '0;
          skip_cnt_d = '0;
          if (skip != '0)           state_d = WARMUP;
          else if (n_samples != '0) state_d = RUN;
          else                      state_d = DONE;
        end
      end
      WARMUP: begin
        if (data_valid) begin
          skip_cnt_d = skip_inc;
          if (skip_inc == skip_lat) state_d = (n_lat != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (data_valid) begin
          sig_d = misr;
          cnt_d = cnt_inc;
          if (cnt_inc == n_lat) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Compare against the values DONE will hold; they are frozen there, so re-evaluating each DONE cycle is stable.
    match_d = (state_d == DONE) && (sig_d == exp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sig      <= SEED;
      cnt      <= '0;
      skip_cnt <= '0;
      n_lat    <= '0;
      skip_lat <= '0;
      exp_lat  <= '0;
      match_r  <= 1'b0;
    end else begin
      state    <= state_d;
      sig      <= sig_d;
      cnt      <= cnt_d;
      skip_cnt <= skip_cnt_d;
      n_lat    <= n_d;
      skip_lat <= skip_d;
      exp_lat  <= exp_d;
      match_r  <= match_d;
    end
  end

  assign busy      = (state == WARMUP) || (state == RUN);
  assign res_valid = (state == DONE);
  assign sig_out   = sig;
  assign cnt_out   = cnt;
  assign match     = match_r;

endmodule

// File: tb/tb_resp_sig_compactor.sv
// Bench for resp_sig_compactor: fixed vector table, hand-written corner sequences,
// and randomized runs checked against a polynomial-arithmetic reference model.
module tb_resp_sig_compactor;

  localparam int          DW     = 330;
  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED_C = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   n_samples = '0;
  logic [15:0]   skip = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic [31:0]   exp_sig = '0;
  logic          busy;
  logic [31:0]   sig_out;
  logic [15:0]   cnt_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          match;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] stim [0:63];

  resp_sig_compactor #(
    .DATA_W(DW), .SIG_W(32), .POLY(POLY_C), .SEED(SEED_C), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .skip(skip),
    .data_in(data_in), .data_valid(data_valid), .exp_sig(exp_sig), .busy(busy),
    .sig_out(sig_out), .cnt_out(cnt_out), .res_valid(res_valid),
    .res_ready(res_ready), .match(match)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: bit i of the bus lands in signature bit i mod 32; the register multiplies by x mod POLY.
  function automatic logic [31:0] ref_fold(input logic [DW-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DW; i++) if (d[i]) f[i % 32] = ~f[i % 32];
    return f;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [DW-1:0] d);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY_C};
    return t[31:0] ^ ref_fold(d);
  endfunction

  function automatic logic [31:0] model_sig(input int sk, input int n);
    logic [31:0] s;
    s = SEED_C;
    for (int k = sk; k < sk + n; k++) s = ref_step(s, stim[k[5:0]]);
    return s;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  task automatic do_run(input logic [15:0] sk, input logic [15:0] n, input logic [31:0] ex,
                        input int gap_pct, input int gap_at, input int hold,
                        input logic [31:0] esig, input logic [15:0] ecnt, input logic emat,
                        input string tag);
    int i;
    int cyc;
    bit gapped;
    i = 0; cyc = 0; gapped = 0;
    @(posedge clk); #1;
    start = 1'b1; skip = sk; n_samples = n; exp_sig = ex; data_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (sk == 0 && n == 0) begin
      chk({tag, ".busy"}, 64'(busy), 64'(0));
      chk({tag, ".rv_direct"}, 64'(res_valid), 64'(1));
    end else begin
      chk({tag, ".busy"}, 64'(busy), 64'(1));
    end
    while (!res_valid && cyc < 500) begin
      if ((gap_at == i && !gapped) || ($urandom_range(0, 99) < gap_pct)) begin
        data_valid = 1'b0; data_in = '1; gapped = 1;
      end else begin
        data_valid = 1'b1; data_in = stim[i[5:0]];
      end
      @(posedge clk); #1;
      if (data_valid) i++;
      cyc++;
    end
    data_valid = 1'b0;
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(1));
    chk({tag, ".busy_done"}, 64'(busy), 64'(0));
    chk({tag, ".consumed"}, 64'(i), 64'(sk) + 64'(n));
    chk({tag, ".sig"}, 64'(sig_out), 64'(esig));
    chk({tag, ".cnt"}, 64'(cnt_out), 64'(ecnt));
    chk({tag, ".match"}, 64'(match), 64'(emat));
    for (int h = 0; h < hold; h++) begin
      data_valid = 1'b1; data_in = rand_data();
      if (h == 1) begin
        start = 1'b1; n_samples = 16'd5; skip = '0; exp_sig = ~ex;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, ".hold_rv"}, 64'(res_valid), 64'(1));
      chk({tag, ".hold_sig"}, 64'(sig_out), 64'(esig));
      chk({tag, ".hold_match"}, 64'(match), 64'(emat));
    end
    start = 1'b0; data_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, ".rv_after_hs"}, 64'(res_valid), 64'(0));
    chk({tag, ".busy_idle"}, 64'(busy), 64'(0));
    chk({tag, ".match_idle"}, 64'(match), 64'(0));
    chk({tag, ".sig_held"}, 64'(sig_out), 64'(esig));
    chk({tag, ".cnt_held"}, 64'(cnt_out), 64'(ecnt));
  endtask

  typedef struct {
    logic [15:0]   sk;
    logic [15:0]   n;
    logic [31:0]   ex;
    logic [DW-1:0] dat;
    logic [31:0]   esig;
    logic [15:0]   ecnt;
    logic          emat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [DW-1:0] d;
    logic [31:0]   es, ex;
    int            sk, n;

    d = '0;
    tbl[0] = '{16'd0, 16'd1, 32'h0,        d, 32'hFB3EE249, 16'd1, 1'b0};
    tbl[1] = '{16'd0, 16'd0, 32'hFFFFFFFF, d, 32'hFFFFFFFF, 16'd0, 1'b1};
    d[0] = 1'b1; d[32] = 1'b1;
    tbl[2] = '{16'd0, 16'd1, 32'hFB3EE249, d, 32'hFB3EE249, 16'd1, 1'b1};
    d = '0; d[329] = 1'b1;
    tbl[3] = '{16'd0, 16'd1, 32'h0,        d, 32'hFB3EE049, 16'd1, 1'b0};
    d = '0;
    tbl[4] = '{16'd0, 16'd2, 32'hF2BCD925, d, 32'hF2BCD925, 16'd2, 1'b1};
    d = '1;
    tbl[5] = '{16'd3, 16'd0, 32'hFFFFFFFF, d, 32'hFFFFFFFF, 16'd0, 1'b1};

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset.sig", 64'(sig_out), 64'(SEED_C));
    chk("reset.cnt", 64'(cnt_out), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.rv", 64'(res_valid), 64'(0));
    chk("reset.match", 64'(match), 64'(0));

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 64; k++) stim[k] = tbl[v].dat;
      do_run(tbl[v].sk, tbl[v].n, tbl[v].ex, 0, -1, 0,
             tbl[v].esig, tbl[v].ecnt, tbl[v].emat, $sformatf("tbl%0d", v));
    end

    // Two discarded samples with an idle gap between them, then one zero sample.
    stim[0] = rand_data() | DW'(1);
    stim[1] = rand_data() | DW'(1);
    stim[2] = '0;
    do_run(16'd2, 16'd1, 32'hFB3EE249, 0, 1, 0, 32'hFB3EE249, 16'd1, 1'b1, "skipgap");

    // Result held for five cycles with a stray start in DONE.
    for (int k = 0; k < 64; k++) stim[k] = '0;
    do_run(16'd0, 16'd1, 32'hFB3EE249, 0, -1, 5, 32'hFB3EE249, 16'd1, 1'b1, "hold");

    // Reset in the middle of a run.
    @(posedge clk); #1;
    start = 1'b1; skip = '0; n_samples = 16'd10; exp_sig = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      data_valid = 1'b1; data_in = rand_data();
      @(posedge clk); #1;
    end
    chk("midrst.busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.sig", 64'(sig_out), 64'(SEED_C));
    chk("midrst.cnt", 64'(cnt_out), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    for (int c = 0; c < 12; c++) begin
      data_valid = 1'b1; data_in = rand_data();
      @(posedge clk); #1;
      chk("midrst.no_result", 64'(res_valid), 64'(0));
    end
    data_valid = 1'b0;
    for (int k = 0; k < 64; k++) stim[k] = '0;
    do_run(16'd0, 16'd1, 32'h0, 0, -1, 0, 32'hFB3EE249, 16'd1, 1'b0, "after_rst");

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      sk = int'($urandom_range(0, 4));
      n  = int'($urandom_range(0, 20));
      for (int k = 0; k < 64; k++) stim[k] = rand_data();
      es = model_sig(sk, n);
      ex = ($urandom_range(0, 1) == 1) ? es : (es ^ 32'h1);
      do_run(16'(sk), 16'(n), ex, 30, -1, (r % 3 == 0) ? 2 : 0,
             es, 16'(n), (ex == es), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
